// File: rtl/pdm_transmitter_if.sv
// pdm_transmitter_if: control, load handshake and PDM output bundle
// for the PDM transmitter.
interface pdm_transmitter_if #(
    parameter int WORD_LENGTH = 16
);
    logic                   enable_i;
    logic [WORD_LENGTH-1:0] data_i;
    logic                   load_i;
    logic                   ready_o;
    logic                   done_o;
    logic                   busy_o;
    logic                   underrun_o;
    logic                   pdm_clk_o;
    logic                   pdm_data_o;

    modport master (
        output enable_i, data_i, load_i,
        input  ready_o, done_o, busy_o,
        input  underrun_o, pdm_clk_o, pdm_data_o
    );

    modport slave (
        input  enable_i, data_i, load_i,
        output ready_o, done_o, busy_o,
        output underrun_o, pdm_clk_o, pdm_data_o
    );
endinterface

// File: rtl/pdm_transmitter.sv
// pdm_transmitter: MSB-first word-to-PDM serializer with a one-word
// holding buffer, generated PDM clock and 1010 idle fill on underrun.
module pdm_transmitter #(
    parameter int WORD_LENGTH        = 16,
    parameter int SYSTEM_FREQUENCY   = 100000000,
    parameter int SAMPLING_FREQUENCY = 1000000
) (
    input  logic             clock_i,
    input  logic             reset_i,
    pdm_transmitter_if.slave bus
);
    localparam int DIVIDER = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
    localparam int DIV_W   = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
    localparam int BIT_W   = (WORD_LENGTH > 2) ? $clog2(WORD_LENGTH) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIVIDER - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIVIDER / 2);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(WORD_LENGTH - 1);

    function automatic logic [WORD_LENGTH-1:0] idle_word();
        logic [WORD_LENGTH-1:0] v;
        v = '0;
        for (int i = 0; i < WORD_LENGTH; i++)
            v[i] = (((WORD_LENGTH - 1 - i) % 2) == 0);
        return v;
    endfunction

    localparam logic [WORD_LENGTH-1:0] IDLE_WORD = idle_word();

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [BIT_W-1:0]       r_bit_idx;
    logic [WORD_LENGTH-1:0] r_shift;
    logic [WORD_LENGTH-1:0] r_buf;
    logic                   r_full;
    logic                   r_under;
    logic                   r_pdm_clk;
    logic                   r_pdm_data;

    logic                   w_last;
    logic                   w_start;
    logic                   w_shift_load;
    logic                   w_done;
    logic                   w_idle_fill;
    logic                   w_take_buf;
    logic                   w_accept;
    logic [WORD_LENGTH-1:0] w_word;
    logic [DIV_W-1:0]       w_div_next;

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next state, word boundary decode and next-word selection.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_shift_load = 1'b0;
        w_done       = 1'b0;
        w_idle_fill  = 1'b0;
        w_word       = IDLE_WORD;
        w_last       = (r_div_cnt == DIV_MAX) && (r_bit_idx == BIT_MAX);

        case (r_state)
            S_IDLE: begin
                if (bus.enable_i) begin
                    w_next_state = S_RUN;
                    w_start      = 1'b1;
                    w_shift_load = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_done = 1'b1;
                    if (bus.enable_i)
                        w_shift_load = 1'b1;
                    else
                        w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        if (r_full)
            w_word = r_buf;
        else if (bus.load_i)
            w_word = bus.data_i;
        else
            w_idle_fill = w_shift_load;

        w_take_buf = w_shift_load & r_full;
        w_accept   = bus.load_i & ~r_full & ~w_shift_load;

        if (w_next_state == S_IDLE || w_shift_load || r_div_cnt == DIV_MAX)
            w_div_next = '0;
        else
            w_div_next = r_div_cnt + 1'b1;
    end

    // Holding buffer: filled by an accepted load, drained at a boundary.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_buf  <= '0;
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_buf  <= bus.data_i;
            r_full <= 1'b1;
        end else if (w_take_buf) begin
            r_full <= 1'b0;
        end
    end

    // Sticky underrun, re-armed at each start.
    always_ff @(posedge clock_i) begin
        if (reset_i)
            r_under <= 1'b0;
        else if (w_start)
            r_under <= w_idle_fill;
        else if (w_idle_fill)
            r_under <= 1'b1;
    end

    // Bit-period divider and PDM clock, high in the second half of a bit.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_div_cnt <= '0;
            r_pdm_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_pdm_clk <= (w_next_state == S_RUN) && (w_div_next >= DIV_HALF);
        end
    end

    // Shifter and data bit; the MSB goes out directly on a word load.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_pdm_data <= 1'b0;
        end else if (w_next_state == S_IDLE) begin
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_pdm_data <= 1'b0;
        end else if (w_shift_load) begin
            r_bit_idx  <= '0;
            r_shift    <= w_word << 1;
            r_pdm_data <= w_word[WORD_LENGTH-1];
        end else if (r_div_cnt == DIV_MAX) begin
            r_bit_idx  <= r_bit_idx + 1'b1;
            r_shift    <= r_shift << 1;
            r_pdm_data <= r_shift[WORD_LENGTH-1];
        end
    end

    assign bus.ready_o    = ~r_full;
    assign bus.done_o     = w_done;
    assign bus.busy_o     = (r_state == S_RUN);
    assign bus.underrun_o = r_under;
    assign bus.pdm_clk_o  = r_pdm_clk;
    assign bus.pdm_data_o = r_pdm_data;
endmodule

// File: tb/tb_pdm_transmitter.sv
// tb_pdm_transmitter: directed and random stimulus against a time-based
// reference model plus a bit-level receiver that reassembles words.
module tb_pdm_transmitter;
    localparam int WL  = 16;
    localparam int D   = 8;
    localparam int WPD = WL * D;

    logic clk;
    logic reset_i;

    pdm_transmitter_if #(.WORD_LENGTH(WL)) bus ();

    pdm_transmitter #(
        .WORD_LENGTH       (WL),
        .SYSTEM_FREQUENCY  (100000000),
        .SAMPLING_FREQUENCY(100000000 / D)
    ) dut (
        .clock_i(clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit          rst;
    bit          en;
    bit          ld;
    logic [15:0] dat;

    bit          m_valid;
    bit          m_run;
    int          m_t;
    logic [15:0] m_word;
    bit          m_full;
    logic [15:0] m_buf;
    bit          m_under;
    logic [15:0] idle_pat;
    logic [15:0] exp_q[$];

    bit          prev_clk;
    logic [15:0] rx;
    int          rx_cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_out();
        int  ph;
        int  bi;
        int  wt;
        logic dbit;
        logic cbit;
        logic done;
        dbit = 1'b0;
        cbit = 1'b0;
        done = 1'b0;
        if (m_run) begin
            wt   = m_t % WPD;
            ph   = m_t % D;
            bi   = wt / D;
            dbit = m_word[WL-1-bi];
            cbit = (ph >= D / 2);
            done = (wt == WPD - 1);
        end
        return {m_run, done, m_under, ~m_full, cbit, dbit};
    endfunction

    task automatic model_step(input bit r, input bit e, input bit l,
                              input logic [15:0] d);
        bit          be;
        bit          take;
        bit          fill;
        logic [15:0] w;
        if (r) begin
            m_valid = 1'b1;
            m_run   = 1'b0;
            m_t     = 0;
            m_word  = '0;
            m_full  = 1'b0;
            m_buf   = '0;
            m_under = 1'b0;
            exp_q.delete();
            rx_cnt   = 0;
            prev_clk = 1'b0;
        end else begin
            be   = m_run && ((m_t % WPD) == WPD - 1);
            take = e && (!m_run || be);
            if (take) begin
                fill = 1'b0;
                if (m_full) begin
                    w      = m_buf;
                    m_full = 1'b0;
                end else if (l) begin
                    w = d;
                end else begin
                    w    = idle_pat;
                    fill = 1'b1;
                end
                if (!m_run) begin
                    m_under = fill;
                    m_run   = 1'b1;
                    m_t     = 0;
                end else begin
                    m_under = m_under | fill;
                    m_t++;
                end
                m_word = w;
                exp_q.push_back(w);
            end else begin
                if (l && !m_full) begin
                    m_full = 1'b1;
                    m_buf  = d;
                end
                if (be) begin
                    m_run = 1'b0;
                    m_t   = 0;
                end else if (m_run) begin
                    m_t++;
                end
            end
        end
    endtask

    task automatic tick();
        logic [5:0]  got;
        logic [15:0] w;
        @(negedge clk);
        if (m_valid) begin
            got = {bus.busy_o, bus.done_o, bus.underrun_o,
                   bus.ready_o, bus.pdm_clk_o, bus.pdm_data_o};
            chk("outputs{busy,done,under,ready,clk,data}", got, model_out());
            if (!prev_clk && bus.pdm_clk_o) begin
                rx = {rx[14:0], bus.pdm_data_o};
                rx_cnt++;
                if (rx_cnt == WL) begin
                    rx_cnt = 0;
                    chk("rx_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        chk("rx_word", rx, w);
                    end
                end
            end
            prev_clk = bus.pdm_clk_o;
        end
        reset_i      = rst;
        bus.enable_i = en;
        bus.load_i   = ld;
        bus.data_i   = dat;
        model_step(rst, en, ld, dat);
    endtask

    task automatic load_word(input logic [15:0] d);
        ld  = 1'b1;
        dat = d;
        tick();
        ld  = 1'b0;
    endtask

    task automatic run_idle();
        en = 1'b0;
        for (int g = 0; g < 2 * WPD + 4 && m_run; g++)
            tick();
        tick();
        chk("stopped_busy", bus.busy_o, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            idle_pat[i] = ((15 - i) % 2) == 0;
        m_valid      = 1'b0;
        prev_clk     = 1'b0;
        rx           = '0;
        rx_cnt       = 0;
        bus.enable_i = 1'b0;
        bus.load_i   = 1'b0;
        bus.data_i   = '0;
        reset_i      = 1'b1;
        rst = 1'b1;
        en  = 1'b0;
        ld  = 1'b0;
        dat = '0;

        // reset held 3 cycles while enable toggles
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // single word
        load_word(16'hA5C3);
        en = 1'b1;
        tick();
        run_idle();

        // streaming two words back to back
        load_word(16'h1234);
        en = 1'b1;
        tick();
        for (int g = 0; g < WPD && m_full; g++)
            tick();
        load_word(16'hFFFF);
        for (int g = 0; g < 2 * WPD && m_full; g++)
            tick();
        run_idle();

        // underrun then late load
        en = 1'b1;
        tick();
        repeat (3 * D) tick();
        load_word(16'h00FF);
        for (int g = 0; g < 2 * WPD && m_full; g++)
            tick();
        run_idle();

        // boundary bypass, then a dropped load
        load_word(16'h3C5A);
        en = 1'b1;
        tick();
        for (int g = 0; g < 2 * WPD &&
             !(m_run && (m_t % WPD) == WPD - 1); g++)
            tick();
        load_word(16'h5A5A);
        repeat (D) tick();
        load_word(16'h1111);
        load_word(16'h2222);
        for (int g = 0; g < 2 * WPD && m_full; g++)
            tick();
        run_idle();

        // stop at bit 5
        load_word(16'h0F0F);
        en = 1'b1;
        tick();
        for (int g = 0; g < WPD && m_t != 5 * D; g++)
            tick();
        run_idle();

        // reset at bit 8 of the second word
        load_word(16'h6789);
        en = 1'b1;
        tick();
        for (int g = 0; g < 2 * WPD && m_t != WPD + 8 * D; g++)
            tick();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();

        // random traffic
        en = 1'b1;
        for (int i = 0; i < 16000; i++) begin
            if ($urandom_range(0, 399) == 0)
                en = ~en;
            ld  = ($urandom_range(0, 15) == 0);
            dat = 16'($urandom);
            rst = ($urandom_range(0, 4999) == 0);
            tick();
        end
        ld  = 1'b0;
        rst = 1'b0;
        run_idle();
        repeat (4) tick();
        chk("rx_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
